// File: rtl/solve_move_replayer_if.sv
// solve_move_replayer_if: valid/ready move handshake from the replayer to the puzzle-state logic
interface solve_move_replayer_if #(parameter int MOVE_W = 4);
   logic              move_valid;
   logic [MOVE_W-1:0] move_data;
   logic              move_ready;
   modport master (output move_valid, output move_data, input move_ready);
   modport slave  (input move_valid, input move_data, output move_ready);
endinterface

// File: rtl/solve_move_replayer.sv
// solve_move_replayer: LIFO replay of recorded shuffle moves, inverted, with an audible beep per move
module solve_move_replayer #(
   parameter int DEPTH       = 16,
   parameter int MOVE_W      = 4,
   parameter int TONE_HALF   = 113636,
   parameter int BEEP_CYCLES = 10000000,
   parameter int GAP_CYCLES  = 5000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_solve_en,
   input  logic                       i_push_valid,
   input  logic [MOVE_W-1:0]          i_push_move,
   input  logic                       i_start,
   solve_move_replayer_if.master      mv,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [$clog2(DEPTH):0]     o_depth,
   output logic                       o_overflow,
   output logic                       o_audio_out,
   output logic                       o_amp_gain,
   output logic                       o_amp_shdn
);
   localparam int AW   = $clog2(DEPTH);
   localparam int DW   = AW + 1;
   localparam int TW   = TONE_HALF > 1 ? $clog2(TONE_HALF) : 1;
   localparam int CMAX = BEEP_CYCLES > GAP_CYCLES ? BEEP_CYCLES : GAP_CYCLES;
   localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
   localparam logic [DW-1:0]     FULL      = DW'(DEPTH);
   localparam logic [TW-1:0]     TONE_LAST = TW'(TONE_HALF - 1);
   localparam logic [CW-1:0]     BEEP_LAST = CW'(BEEP_CYCLES - 1);
   localparam logic [CW-1:0]     GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [MOVE_W-1:0] DIR       = MOVE_W'(1) << (MOVE_W - 1);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_POP     = 3'd1;
   localparam logic [2:0] S_PRESENT = 3'd2;
   localparam logic [2:0] S_BEEP    = 3'd3;
   localparam logic [2:0] S_GAP     = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]        r_state;
   logic [DW-1:0]     r_depth;
   logic [MOVE_W-1:0] r_mem [DEPTH];
   logic [MOVE_W-1:0] r_data;
   logic              r_valid, r_overflow, r_audio, r_shdn;
   logic [TW-1:0]     r_tone;
   logic [CW-1:0]     r_cnt;
   logic              w_idle, w_push, w_wr, w_go, w_abort;
   logic [AW-1:0]     w_top;

   assign w_idle  = r_state == S_IDLE;
   assign w_push  = w_idle & ~i_solve_en & i_push_valid;
   assign w_wr    = w_push & (r_depth != FULL);
   assign w_go    = w_idle & i_solve_en & i_start;
   assign w_abort = ~i_solve_en & ~w_idle & (r_state != S_DONE);
   assign w_top   = AW'(r_depth - 1'b1);

   // stack storage; the depth count doubles as the stack pointer
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_depth[AW-1:0]] <= i_push_move;
   end

   // record/replay state machine with beep tone and gap timing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_depth    <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
         r_audio    <= 1'b0;
         r_shdn     <= 1'b0;
         r_tone     <= '0;
         r_cnt      <= '0;
      end else begin
         r_shdn <= 1'b1;
         if (w_wr) r_depth <= r_depth + 1'b1;
         if (w_push && r_depth == FULL) r_overflow <= 1'b1;
         if (w_go) r_overflow <= 1'b0;
         if (w_abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_audio <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: if (w_go) r_state <= r_depth == '0 ? S_DONE : S_POP;
               S_POP: begin
                  r_depth <= r_depth - 1'b1;
                  r_data  <= r_mem[w_top] ^ DIR;
                  r_valid <= 1'b1;
                  r_state <= S_PRESENT;
               end
               S_PRESENT: if (mv.move_ready) begin
                  r_valid <= 1'b0;
                  r_cnt   <= '0;
                  r_tone  <= '0;
                  r_audio <= 1'b1;
                  r_state <= S_BEEP;
               end
               S_BEEP: if (r_cnt == BEEP_LAST) begin
                  r_cnt   <= '0;
                  r_audio <= 1'b0;
                  r_state <= S_GAP;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_tone  <= r_tone == TONE_LAST ? '0 : r_tone + 1'b1;
                  r_audio <= r_tone == TONE_LAST ? ~r_audio : r_audio;
               end
               S_GAP: if (r_cnt == GAP_LAST) r_state <= r_depth != '0 ? S_POP : S_DONE;
                      else r_cnt <= r_cnt + 1'b1;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign mv.move_valid = r_valid;
   assign mv.move_data  = r_data;
   assign o_busy        = ~w_idle;
   assign o_done        = r_state == S_DONE;
   assign o_depth       = r_depth;
   assign o_overflow    = r_overflow;
   assign o_audio_out   = r_audio;
   assign o_amp_gain    = 1'b1;
   assign o_amp_shdn    = r_shdn;
endmodule

// File: tb/tb_solve_move_replayer.sv
// tb_solve_move_replayer: randomized check of the move replayer against a queue-based stack model
module tb_solve_move_replayer;
   localparam int DEPTH = 4, MOVE_W = 4, TH = 3, BC = 12, GC = 5;

   logic       clk = 1'b0, rst = 1'b1;
   logic       solve_en = 1'b0, push_valid = 1'b0, start = 1'b0;
   logic [3:0] push_move = '0;
   logic       busy, done, overflow, audio_out, amp_gain, amp_shdn;
   logic [2:0] depth;
   int         n_chk = 0, n_err = 0;
   logic [3:0] model[$];
   logic       model_ovf = 1'b0;

   solve_move_replayer_if #(.MOVE_W(MOVE_W)) mv();

   solve_move_replayer #(.DEPTH(DEPTH), .MOVE_W(MOVE_W), .TONE_HALF(TH), .BEEP_CYCLES(BC), .GAP_CYCLES(GC)) dut (
      .clk(clk), .rst(rst), .i_solve_en(solve_en), .i_push_valid(push_valid), .i_push_move(push_move),
      .i_start(start), .mv(mv), .o_busy(busy), .o_done(done), .o_depth(depth), .o_overflow(overflow),
      .o_audio_out(audio_out), .o_amp_gain(amp_gain), .o_amp_shdn(amp_shdn));

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(string tag);
      check({tag, "_depth"}, depth, 0);
      check({tag, "_valid"}, mv.move_valid, 0);
      check({tag, "_data"}, mv.move_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_audio"}, audio_out, 0);
      check({tag, "_gain"}, amp_gain, 1);
      check({tag, "_shdn"}, amp_shdn, 0);
   endtask

   task automatic push(logic [3:0] m);
      solve_en = 1'b0; push_valid = 1'b1; push_move = m;
      step();
      push_valid = 1'b0;
      if (model.size() < DEPTH) model.push_back(m);
      else model_ovf = 1'b1;
      check("push_depth", depth, model.size());
      check("push_ovf", overflow, model_ovf);
   endtask

   // hold < 0 picks a random 0..3 cycle stall per move
   task automatic replay(int hold);
      logic [3:0] exp;
      int w;
      solve_en = 1'b1; start = 1'b1;
      step();
      start = 1'b0; model_ovf = 1'b0;
      check("start_ovf_clr", overflow, 0);
      if (model.size() == 0) begin
         check("empty_done", done, 1);
         check("empty_valid", mv.move_valid, 0);
         step();
         check("empty_done_end", done, 0);
         check("empty_idle", busy, 0);
         check("empty_valid2", mv.move_valid, 0);
         return;
      end
      check("pop_busy", busy, 1);
      check("pop_valid", mv.move_valid, 0);
      while (model.size() > 0) begin
         step();
         exp = model.pop_back() ^ 4'h8;
         check("present_valid", mv.move_valid, 1);
         check("present_data", mv.move_data, exp);
         check("present_depth", depth, model.size());
         w = hold < 0 ? int'($urandom_range(3, 0)) : hold;
         for (int i = 0; i < w; i++) begin
            step();
            check("hold_valid", mv.move_valid, 1);
            check("hold_data", mv.move_data, exp);
            check("hold_audio", audio_out, 0);
         end
         mv.move_ready = 1'b1;
         step();
         mv.move_ready = 1'b0;
         check("beep_valid", mv.move_valid, 0);
         for (int i = 0; i < BC; i++) begin
            check("beep_audio", audio_out, ((i / TH) % 2) == 0);
            check("beep_done", done, 0);
            step();
         end
         for (int j = 0; j < GC; j++) begin
            check("gap_audio", audio_out, 0);
            check("gap_done", done, 0);
            check("gap_busy", busy, 1);
            step();
         end
         if (model.size() > 0) begin
            check("pop_valid", mv.move_valid, 0);
            check("pop_done", done, 0);
         end
      end
      check("final_done", done, 1);
      step();
      check("final_done_end", done, 0);
      check("final_idle", busy, 0);
      check("final_depth", depth, 0);
   endtask

   initial begin
      logic [3:0] exp;
      mv.move_ready = 1'b0;
      #1;
      check_reset("rst_async");
      repeat (3) step();
      check_reset("rst_held");
      rst = 1'b0;
      step();
      check("shdn_up", amp_shdn, 1);
      check("gain_const", amp_gain, 1);

      push(4'h1); push(4'h2); push(4'hA);
      replay(0);

      for (int i = 0; i < 5; i++) push(4'($urandom_range(15, 0)));
      check("full_ovf", overflow, 1);
      replay(-1);

      push(4'h3);
      replay(20);

      replay(0);

      solve_en = 1'b1; push_valid = 1'b1; push_move = 4'h5;
      step();
      push_valid = 1'b0;
      check("solve_push_ignored", depth, model.size());
      check("solve_push_no_ovf", overflow, 0);
      solve_en = 1'b0; start = 1'b1;
      push(4'h6);
      start = 1'b0;
      check("record_start_ignored", busy, 0);
      push(4'h7); push(4'h9);
      solve_en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      exp = model.pop_back() ^ 4'h8;
      check("abort_present", mv.move_data, exp);
      mv.move_ready = 1'b1;
      step();
      mv.move_ready = 1'b0;
      step(); step();
      solve_en = 1'b0;
      step();
      check("abort_idle", busy, 0);
      check("abort_audio", audio_out, 0);
      check("abort_depth", depth, model.size());
      check("abort_done", done, 0);
      check("abort_valid", mv.move_valid, 0);

      solve_en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("rst_mid_valid", mv.move_valid, 1);
      #2 rst = 1'b1;
      #1;
      check_reset("rst_mid");
      model.delete();
      model_ovf = 1'b0;
      rst = 1'b0;
      step();
      check("shdn_up2", amp_shdn, 1);

      repeat (6) begin
         for (int i = $urandom_range(6, 0); i > 0; i--) push(4'($urandom_range(15, 0)));
         replay(-1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
